// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: shadow-pipeline entry,
// FSM state encoding and default geometry constants.
package pipe_pkg;

  localparam int NSTAGE_DEF  = 3;
  localparam int RADDR_W_DEF = 5;
  // Entries carry rd at this fixed width so the struct needs no parameter.
  localparam int RD_MAX_W    = 8;

  typedef struct packed {
    logic                valid;
    logic                rf_we;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
    logic                halt;
  } pipe_entry_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } pipe_state_t;

endpackage

// File: rtl/pipe_fwd_match.sv
// Priority match of one decode source register against all shadow entries;
// reports the youngest matching stage and whether it forces a stall.
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int NSTAGE     = NSTAGE_DEF,
  parameter int LOAD_STAGE = 2,
  parameter bit FWD_EN     = 1'b0
) (
  input  pipe_entry_t [NSTAGE-1:0]         entries,
  input  logic        [RD_MAX_W-1:0]       rs,
  input  logic                             rs_use,
  output logic                             stall,
  output logic                             hit,
  output logic        [$clog2(NSTAGE)-1:0] idx
);

  localparam int IDX_W = $clog2(NSTAGE);

  logic found;
  logic found_load;
  logic below_load;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    found      = 1'b0;
    found_load = 1'b0;
    idx        = '0;
    // Oldest to youngest, so the youngest (lowest index) match is kept.
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (entries[k].valid && entries[k].rf_we && (entries[k].rd != '0) &&
          (entries[k].rd == rs) && rs_use) begin
        found      = 1'b1;
        found_load = entries[k].is_load;
        idx        = IDX_W'(k);
      end
    end
  end

  assign below_load = (int'(idx) < LOAD_STAGE);

  // Without forwarding any in-flight writer interlocks; with it only an
  // unfinished load does.
  assign stall = FWD_EN ? (found & found_load & below_load) : found;
  assign hit   = FWD_EN ? (found & ~stall) : 1'b0;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the in-order core: RAW interlock, redirect flush and
// ebreak drain/halt. Define PIPE_HAZARD_FORWARD_EN to build operand forwarding.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGE     = NSTAGE_DEF,
  parameter int XLEN       = 64,
  parameter int RADDR_W    = RADDR_W_DEF,
  parameter int LOAD_STAGE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [RADDR_W-1:0]     id_rs1,
  input  logic [RADDR_W-1:0]     id_rs2,
  input  logic                   id_rs1_use,
  input  logic                   id_rs2_use,
  input  logic                   id_rf_we,
  input  logic [RADDR_W-1:0]     id_rd,
  input  logic                   id_is_load,
  input  logic                   id_halt,
  input  logic                   redirect,
  input  logic [NSTAGE*XLEN-1:0] stage_data,
  output logic                   if_ena,
  output logic                   id_flush,
  output logic                   ex_bubble,
  output logic [NSTAGE-1:0]      stage_valid,
  output logic                   fwd_rs1_hit,
  output logic                   fwd_rs2_hit,
  output logic [XLEN-1:0]        fwd_rs1_data,
  output logic [XLEN-1:0]        fwd_rs2_data,
  output logic [31:0]            stall_cnt,
  output logic                   halted
);

  localparam int IDX_W = $clog2(NSTAGE);
`ifdef PIPE_HAZARD_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  pipe_entry_t [NSTAGE-1:0] entries;
  pipe_entry_t              id_entry;
  pipe_state_t              state, state_next;

  logic             stall1, stall2, hit1, hit2;
  logic [IDX_W-1:0] idx1, idx2;
  logic             in_run, stall, issue;

  always_comb begin
    id_entry         = '0;
    id_entry.valid   = 1'b1;
    id_entry.rf_we   = id_rf_we;
    id_entry.rd      = RD_MAX_W'(id_rd);
    id_entry.is_load = id_is_load;
    id_entry.halt    = id_halt;
  end

  pipe_fwd_match #(.NSTAGE(NSTAGE), .LOAD_STAGE(LOAD_STAGE), .FWD_EN(FWD_EN)) u_match_rs1 (
    .entries (entries),
    .rs      (RD_MAX_W'(id_rs1)),
    .rs_use  (id_rs1_use),
    .stall   (stall1),
    .hit     (hit1),
    .idx     (idx1)
  );

  pipe_fwd_match #(.NSTAGE(NSTAGE), .LOAD_STAGE(LOAD_STAGE), .FWD_EN(FWD_EN)) u_match_rs2 (
    .entries (entries),
    .rs      (RD_MAX_W'(id_rs2)),
    .rs_use  (id_rs2_use),
    .stall   (stall2),
    .hit     (hit2),
    .idx     (idx2)
  );

  // A redirect discards the decode instruction, so its hazards do not count.
  assign in_run    = (state == RUN);
  assign stall     = id_valid & (stall1 | stall2) & ~redirect;
  assign issue     = id_valid & ~stall & ~redirect & in_run;
  assign if_ena    = ~rst & ((~stall & in_run) | redirect);
  assign id_flush  = rst | redirect;
  assign ex_bubble = rst | ~issue;
  assign halted    = (state == HALTED);

  // NOTE: the entry array is reset because its valid bits drive the interlock;
  // a memory holding only data would not need it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage shift from the old value.
      entries[0] <= issue ? id_entry : '0;
      for (int k = 1; k < NSTAGE; k++) begin
        entries[k] <= entries[k-1];
      end
    end
  end

  always_comb begin
    stage_valid = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      stage_valid[k] = entries[k].valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (issue && id_halt) state_next = DRAIN;
      DRAIN:   if (entries[NSTAGE-1].valid && entries[NSTAGE-1].halt) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && in_run && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

`ifdef PIPE_HAZARD_FORWARD_EN
  logic [XLEN-1:0] stage_word [NSTAGE];

  always_comb begin
    for (int k = 0; k < NSTAGE; k++) begin
      stage_word[k] = stage_data[k*XLEN +: XLEN];
    end
  end

  assign fwd_rs1_hit  = hit1;
  assign fwd_rs2_hit  = hit2;
  assign fwd_rs1_data = hit1 ? stage_word[idx1] : '0;
  assign fwd_rs2_data = hit2 ? stage_word[idx2] : '0;
`else
  logic unused_fwd;
  assign unused_fwd   = ^{stage_data, hit1, hit2, idx1, idx2};
  assign fwd_rs1_hit  = 1'b0;
  assign fwd_rs2_hit  = 1'b0;
  assign fwd_rs1_data = '0;
  assign fwd_rs2_data = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed and random decode streams scored against
// an in-flight-list reference model; honours PIPE_HAZARD_FORWARD_EN.
module tb_pipe_hazard_ctrl;

  localparam int NS = 3;
  localparam int XL = 64;
  localparam int RW = 5;
  localparam int LS = 2;
`ifdef PIPE_HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk, rst;
  logic              id_valid, id_rs1_use, id_rs2_use, id_rf_we, id_is_load, id_halt, redirect;
  logic [RW-1:0]     id_rs1, id_rs2, id_rd;
  logic [NS*XL-1:0]  stage_data;
  logic              if_ena, id_flush, ex_bubble, fwd_rs1_hit, fwd_rs2_hit, halted;
  logic [NS-1:0]     stage_valid;
  logic [XL-1:0]     fwd_rs1_data, fwd_rs2_data;
  logic [31:0]       stall_cnt;

  pipe_hazard_ctrl #(.NSTAGE(NS), .XLEN(XL), .RADDR_W(RW), .LOAD_STAGE(LS)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use), .id_rf_we(id_rf_we), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_halt(id_halt), .redirect(redirect), .stage_data(stage_data),
    .if_ena(if_ena), .id_flush(id_flush), .ex_bubble(ex_bubble), .stage_valid(stage_valid),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit), .fwd_rs1_data(fwd_rs1_data),
    .fwd_rs2_data(fwd_rs2_data), .stall_cnt(stall_cnt), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [RW-1:0] rs1, rs2; logic u1, u2, we; logic [RW-1:0] rd; logic ld, hlt;
  } ins_t;
  typedef struct {
    int c; logic we; logic [RW-1:0] rd; logic ld; logic hlt;
  } fl_t;
  typedef struct {
    logic if_ena, id_flush, ex_bubble; logic [NS-1:0] sv; logic h1, h2;
    logic [XL-1:0] d1, d2; logic [31:0] cnt; logic halted;
  } exp_t;

  fl_t         inflight[$];
  exp_t        sb[$];
  int          now    = 0;
  int          halt_t = -1;
  logic [31:0] m_cnt  = 0;
  int          total  = 0;
  int          bad    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic ins_t nop();
    ins_t i;
    i.v = 0; i.rs1 = 0; i.rs2 = 0; i.u1 = 0; i.u2 = 0; i.we = 0; i.rd = 0; i.ld = 0; i.hlt = 0;
    return i;
  endfunction

  function automatic ins_t alu(input int rd, input int rs1, input int rs2);
    ins_t i = nop();
    i.v = 1; i.rd = RW'(rd); i.rs1 = RW'(rs1); i.rs2 = RW'(rs2); i.u1 = 1; i.u2 = 1; i.we = 1;
    return i;
  endfunction

  function automatic ins_t load(input int rd, input int rs1);
    ins_t i = nop();
    i.v = 1; i.rd = RW'(rd); i.rs1 = RW'(rs1); i.u1 = 1; i.we = 1; i.ld = 1;
    return i;
  endfunction

  function automatic ins_t halt_i();
    ins_t i = nop();
    i.v = 1; i.hlt = 1;
    return i;
  endfunction

  function automatic ins_t rnd();
    ins_t i;
    i.v   = ($urandom_range(0, 3) != 0);
    i.rs1 = RW'($urandom_range(0, 3));
    i.rs2 = RW'($urandom_range(0, 3));
    i.u1  = 1'($urandom_range(0, 1));
    i.u2  = 1'($urandom_range(0, 1));
    i.we  = ($urandom_range(0, 3) != 0);
    i.rd  = RW'($urandom_range(0, 3));
    i.ld  = i.we & ($urandom_range(0, 2) == 0);
    i.hlt = 0;
    return i;
  endfunction

  // Youngest in-flight writer of rs decides the stall/forward outcome.
  task automatic look(input logic [RW-1:0] rs, input logic use_, output logic hz,
                      output logic hit, output logic [XL-1:0] data);
    int best;
    int st;
    logic bld;
    best = -1; bld = 0;
    foreach (inflight[j]) begin
      st = now - inflight[j].c - 1;
      if (st >= 0 && st < NS && inflight[j].we && inflight[j].rd != 0 && inflight[j].rd == rs && use_)
        if (best < 0 || st < best) begin
          best = st; bld = inflight[j].ld;
        end
    end
    if (FWD) begin
      hz   = (best >= 0) && bld && (best < LS);
      hit  = (best >= 0) && !hz;
      data = hit ? stage_data[best*XL +: XL] : '0;
    end else begin
      hz   = (best >= 0);
      hit  = 0;
      data = '0;
    end
  endtask

  task automatic model(output logic issued);
    exp_t e;
    logic hz1, hz2, stall, run, iss;
    int   st;
    issued = 0;
    e.sv   = '0;
    if (rst) begin
      inflight.delete(); m_cnt = 0; halt_t = -1;
      e.if_ena = 0; e.id_flush = 1; e.ex_bubble = 1; e.h1 = 0; e.h2 = 0;
      e.d1 = 0; e.d2 = 0; e.cnt = 0; e.halted = 0;
    end else begin
      look(id_rs1, id_rs1_use, hz1, e.h1, e.d1);
      look(id_rs2, id_rs2_use, hz2, e.h2, e.d2);
      foreach (inflight[j]) begin
        st = now - inflight[j].c - 1;
        if (st >= 0 && st < NS) e.sv[st] = 1'b1;
      end
      run         = (halt_t < 0) || (now <= halt_t);
      e.halted    = (halt_t >= 0) && (now >= halt_t + NS + 1);
      stall       = id_valid && (hz1 || hz2) && !redirect;
      iss         = id_valid && !stall && !redirect && run;
      e.if_ena    = (!stall && run) || redirect;
      e.id_flush  = redirect;
      e.ex_bubble = !iss;
      e.cnt       = m_cnt;
      if (stall && run && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (iss) begin
        inflight.push_back('{now, id_rf_we, id_rd, id_is_load, id_halt});
        if (id_halt) halt_t = now;
      end
      issued = iss;
    end
    sb.push_back(e);
    now++;
    while (inflight.size() > 0 && now - inflight[0].c - 1 >= NS) void'(inflight.pop_front());
  endtask

  task automatic step(input ins_t i, input logic rdr, input logic r, output logic issued);
    @(posedge clk);
    #1;
    rst = r; id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rs1_use = i.u1;
    id_rs2_use = i.u2; id_rf_we = i.we; id_rd = i.rd; id_is_load = i.ld; id_halt = i.hlt;
    redirect = rdr;
    for (int k = 0; k < NS; k++) stage_data[k*XL +: XL] = {$urandom, $urandom};
    model(issued);
  endtask

  task automatic hold(input ins_t i);
    logic iss;
    iss = 0;
    for (int n = 0; n < 40 && !iss; n++) step(i, 0, 0, iss);
    if (!iss) check("issue_timeout", 64'(iss), 64'(1));
  endtask

  task automatic idle(input int n);
    logic iss;
    for (int k = 0; k < n; k++) step(nop(), 0, 0, iss);
  endtask

  // Scoreboard monitor: one expected record per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("if_ena",      64'(if_ena),       64'(e.if_ena));
        check("id_flush",    64'(id_flush),     64'(e.id_flush));
        check("ex_bubble",   64'(ex_bubble),    64'(e.ex_bubble));
        check("stage_valid", 64'(stage_valid),  64'(e.sv));
        check("fwd1_hit",    64'(fwd_rs1_hit),  64'(e.h1));
        check("fwd2_hit",    64'(fwd_rs2_hit),  64'(e.h2));
        check("fwd1_data",   fwd_rs1_data,      e.d1);
        check("fwd2_data",   fwd_rs2_data,      e.d2);
        check("stall_cnt",   64'(stall_cnt),    64'(e.cnt));
        check("halted",      64'(halted),       64'(e.halted));
      end
    end
  end

  initial begin
    logic        iss;
    logic        rdr;
    ins_t        cur;
    logic [31:0] base;
    int          w;

    rst = 1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_use = 0; id_rs2_use = 0;
    id_rf_we = 0; id_rd = 0; id_is_load = 0; id_halt = 0; redirect = 0; stage_data = '0;
    step(nop(), 0, 1, iss);
    step(nop(), 0, 1, iss);
    idle(1);

    // Dependent ALU pair.
    @(negedge clk); base = stall_cnt;
    hold(alu(5, 1, 2));
    hold(alu(6, 5, 5));
    @(negedge clk);
    check("raw_stalls", 64'(stall_cnt - base), FWD ? 64'(0) : 64'(NS));
    if (FWD) begin
      check("raw_fwd_hit",  64'(fwd_rs1_hit), 64'(1));
      check("raw_fwd_data", fwd_rs1_data, stage_data[0 +: XL]);
    end

    // Load-use.
    idle(NS + 1);
    @(negedge clk); base = stall_cnt;
    hold(load(7, 1));
    hold(alu(8, 7, 0));
    @(negedge clk);
    check("load_use_stalls", 64'(stall_cnt - base), FWD ? 64'(LS) : 64'(NS));
    if (FWD) check("load_use_data", fwd_rs1_data, stage_data[LS*XL +: XL]);

    // x0 is never a hazard.
    idle(NS + 1);
    @(negedge clk); base = stall_cnt;
    hold(alu(0, 1, 2));
    hold(alu(9, 0, 0));
    @(negedge clk);
    check("x0_stalls", 64'(stall_cnt - base), 64'(0));
    check("x0_hit", 64'(fwd_rs1_hit), 64'(0));

    // Redirect while decode is stalled on a load.
    idle(NS + 1);
    hold(load(5, 1));
    step(alu(6, 5, 0), 0, 0, iss);
    step(alu(6, 5, 0), 1, 0, iss);
    @(negedge clk); base = stall_cnt;
    check("rdr_flush",  64'(id_flush),  64'(1));
    check("rdr_if_ena", 64'(if_ena),    64'(1));
    check("rdr_bubble", 64'(ex_bubble), 64'(1));
    idle(1);
    @(negedge clk);
    check("rdr_cnt_hold", 64'(stall_cnt), 64'(base));

    // ebreak drain then halt, then reset clears it.
    idle(NS + 1);
    hold(halt_i());
    for (int i = 1; i <= NS + 3; i++) begin
      step(alu(3, 1, 2), 0, 0, iss);
      @(negedge clk);
      check("halt_if_ena", 64'(if_ena), 64'(0));
      check("halt_flag", 64'(halted), (i >= NS + 1) ? 64'(1) : 64'(0));
    end
    step(nop(), 0, 1, iss);
    @(negedge clk);
    check("halt_rst", 64'(halted), 64'(0));

    // Reset in the middle of a drain.
    idle(1);
    hold(halt_i());
    idle(1);
    step(nop(), 0, 1, iss);
    step(alu(4, 1, 2), 0, 0, iss);
    @(negedge clk);
    check("drain_rst_run", 64'(if_ena), 64'(1));

    // Random episodes; odd ones finish with an ebreak.
    for (int ep = 0; ep < 6; ep++) begin
      cur = rnd();
      for (int c = 0; c < 150; c++) begin
        rdr = ($urandom_range(0, 9) == 0);
        if (c == 110 && ep[0]) cur = halt_i();
        step(cur, rdr, 0, iss);
        if (iss || rdr || (!cur.hlt && $urandom_range(0, 3) == 0)) cur = rnd();
      end
      step(nop(), 0, 1, iss);
    end
    idle(2);

    w = 0;
    while (sb.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    if (sb.size() > 0) check("sb_drain", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
